// File: rtl/result_uart_reporter.sv
// result_uart_reporter: prints each new CPU result as "XXXXXXXX\r\n" on a UART 8N1 line.
// Ports:
//   clk_in      CPU clock, rising edge
//   rst         asynchronous active-low reset
//   result      32-bit CPU result bus, sampled every cycle
//   en          allows new frames to start; a frame in flight always completes
//   tx          UART serial output, idles high
//   busy        high from frame start until the last stop bit ends
//   frames_sent count of completed frames, wraps to 0
module result_uart_reporter #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic [31:0]      result,
    input  logic             en,
    output logic             tx,
    output logic             busy,
    output logic [CNT_W-1:0] frames_sent
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0] LAST_BYTE = 4'd9;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state, state_nx;
    logic [BAUD_W-1:0]  baud_cnt, baud_nx;
    logic [2:0]         bit_idx, bit_nx;
    logic [3:0]         byte_idx, byte_nx;
    logic [31:0]        snap, snap_nx;
    logic               pending_first, pend_nx;
    logic [CNT_W-1:0]   frames_nx;
    logic               tx_nx, busy_nx;
    logic               bit_end;
    logic [3:0]         nibble;
    logic [7:0]         cur_byte;

    assign bit_end = (baud_cnt == BAUD_LAST);

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        // 0x37 + n maps 10..15 onto 'A'..'F'
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // State and datapath registers
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            baud_cnt      <= '0;
            bit_idx       <= '0;
            byte_idx      <= '0;
            snap          <= '0;
            pending_first <= 1'b1;
            frames_sent   <= '0;
            tx            <= 1'b1;
            busy          <= 1'b0;
        end else begin
            state         <= state_nx;
            baud_cnt      <= baud_nx;
            bit_idx       <= bit_nx;
            byte_idx      <= byte_nx;
            snap          <= snap_nx;
            pending_first <= pend_nx;
            frames_sent   <= frames_nx;
            tx            <= tx_nx;
            busy          <= busy_nx;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_nx  = state;
        baud_nx   = baud_cnt;
        bit_nx    = bit_idx;
        byte_nx   = byte_idx;
        snap_nx   = snap;
        pend_nx   = pending_first;
        frames_nx = frames_sent;
        case (state)
            IDLE: begin
                if (en && (pending_first || (result != snap))) begin
                    snap_nx  = result;
                    pend_nx  = 1'b0;
                    byte_nx  = '0;
                    bit_nx   = '0;
                    baud_nx  = '0;
                    state_nx = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_nx  = '0;
                    bit_nx   = '0;
                    state_nx = DATA;
                end else begin
                    baud_nx = baud_cnt + BAUD_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_nx = '0;
                    if (bit_idx == 3'd7) begin
                        state_nx = STOP;
                    end else begin
                        bit_nx = bit_idx + 3'd1;
                    end
                end else begin
                    baud_nx = baud_cnt + BAUD_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_nx = '0;
                    if (byte_idx == LAST_BYTE) begin
                        frames_nx = frames_sent + CNT_W'(1);
                        state_nx  = IDLE;
                    end else begin
                        byte_nx  = byte_idx + 4'd1;
                        state_nx = START;
                    end
                end else begin
                    baud_nx = baud_cnt + BAUD_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Registered outputs are derived from next-state values so tx/busy line up with the state
    always_comb begin
        nibble = 4'h0;
        case (byte_nx)
            4'd0: nibble = snap_nx[31:28];
            4'd1: nibble = snap_nx[27:24];
            4'd2: nibble = snap_nx[23:20];
            4'd3: nibble = snap_nx[19:16];
            4'd4: nibble = snap_nx[15:12];
            4'd5: nibble = snap_nx[11:8];
            4'd6: nibble = snap_nx[7:4];
            4'd7: nibble = snap_nx[3:0];
            default: nibble = 4'h0;
        endcase
        if (byte_nx == 4'd8) begin
            cur_byte = 8'h0D;
        end else if (byte_nx == LAST_BYTE) begin
            cur_byte = 8'h0A;
        end else begin
            cur_byte = hex_ascii(nibble);
        end
        busy_nx = (state_nx != IDLE);
        case (state_nx)
            START:   tx_nx = 1'b0;
            DATA:    tx_nx = cur_byte[bit_nx];
            default: tx_nx = 1'b1;
        endcase
    end

endmodule
